maxpool_ctrl: RTL
=================

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 256: pixels per row; even, >=2.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 256: rows per frame; even, >=2.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state on its rising edge.
REQ-004 SHALL have port i_reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port i_start, input, 1: frame start request; sampled only in IDLE.
REQ-006 SHALL have port i_data_valid, input, 1: upstream pixel valid.
REQ-007 SHALL have port o_data_ready, output, 1: controller accepts a pixel this cycle.
REQ-008 SHALL have port o_lb_wr_en, output, 1: line-buffer write strobe.
REQ-009 SHALL have port o_lb_rd_en, output, 1: line-buffer read strobe.
REQ-010 SHALL have port o_lb_addr, output, AW=$clog2(IMAGE_WIDTH): line-buffer column address.
REQ-011 SHALL have port o_hold_en, output, 1: datapath latches current pixel into the horizontal hold register.
REQ-012 SHALL have port o_pool_valid, output, 1: 2x2 window complete, max result valid downstream.
REQ-013 SHALL have port o_pool_last, output, 1: qualifies o_pool_valid for the final window of the frame.
REQ-014 SHALL have port i_pool_ready, input, 1: downstream accepts the pooled result.
REQ-015 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-016 SHALL have port o_frame_done, output, 1: one-cycle pulse at frame completion.

Function
REQ-017 SHALL implement states IDLE, EVEN_ROW, ODD_ROW, DONE.
REQ-018 SHALL define accept = i_data_valid && o_data_ready.
REQ-019 SHALL drive o_data_ready = (state is EVEN_ROW or ODD_ROW) && !(o_pool_valid && !i_pool_ready), combinationally.
REQ-020 SHALL move IDLE->EVEN_ROW on i_start, clearing column (col) and row counters; i_start is ignored in all other states.
REQ-021 SHALL increment col on accept; at col==IMAGE_WIDTH-1 col wraps to 0, row increments, and state toggles EVEN_ROW<->ODD_ROW.
REQ-022 SHALL go ODD_ROW->DONE, not EVEN_ROW, on accept at row==IMAGE_HEIGHT-1, col==IMAGE_WIDTH-1.
REQ-023 SHALL drive o_lb_addr = col combinationally in all states.
REQ-024 SHALL drive o_lb_wr_en = accept in EVEN_ROW, else 0.
REQ-025 SHALL drive o_lb_rd_en = accept in ODD_ROW, else 0.
REQ-026 SHALL drive o_hold_en = accept && col[0]==0 in EVEN_ROW and ODD_ROW, else 0.
REQ-027 SHALL set o_pool_valid (registered) the cycle after accept in ODD_ROW with col[0]==1: 1-cycle latency matching line-buffer read latency.
REQ-028 SHALL hold o_pool_valid and o_pool_last until i_pool_ready; o_pool_valid clears on i_pool_ready unless a new window sets it in the same cycle (set wins).
REQ-029 SHALL set o_pool_last with o_pool_valid for the window produced by the REQ-022 transition.
REQ-030 SHALL remain in DONE until o_pool_valid is 0 or i_pool_ready is 1, then go to IDLE and pulse o_frame_done (registered) for exactly one cycle.
REQ-031 SHALL emit exactly (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) windows per frame.
REQ-032 SHALL size the row counter as $clog2(IMAGE_HEIGHT) bits, with no overflow past IMAGE_HEIGHT-1.

Reset
REQ-033 SHALL on i_reset asynchronously force state IDLE, col=0, row=0, o_pool_valid=0, o_pool_last=0, o_frame_done=0.
REQ-034 SHALL while reset or IDLE drive o_data_ready=0, o_lb_wr_en=0, o_lb_rd_en=0, o_hold_en=0, o_busy=0, o_lb_addr=0.
REQ-035 SHALL on reset mid-frame abandon the frame: no o_frame_done, pending window discarded.

Configuration
REQ-036 SHALL, when macro MAXPOOL_CTRL_STATS_EN is defined, add output o_window_count (width $clog2((IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2))+1): windows accepted by downstream (o_pool_valid && i_pool_ready) this frame; cleared on i_reset and on i_start in IDLE; holds its value in IDLE.
REQ-037 SHALL, without MAXPOOL_CTRL_STATS_EN, omit o_window_count and its logic; all other behaviour is identical.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=4)
REQ-038 SHALL cover: i_start, then 16 pixels with i_data_valid=1 and i_pool_ready=1 -> o_lb_wr_en on pixels 0-3 and 8-11; o_pool_valid one cycle after pixels 5, 7, 13 and 15; o_pool_last only on the 4th window; o_frame_done one cycle after the 4th window.
REQ-039 SHALL cover: i_pool_ready=0 at the first window -> o_pool_valid held and o_data_ready=0 until i_pool_ready=1; no pixel lost; window count still 4.
REQ-040 SHALL cover: i_data_valid toggled 1/0 every cycle -> identical write, read, hold and window sequence to REQ-038, stretched in time.
REQ-041 SHALL cover: i_reset pulse after pixel 6 -> all outputs at reset values; no o_frame_done; a new i_start completes a clean frame.
REQ-042 SHALL cover: i_start asserted during ODD_ROW -> ignored; counters unaffected.
REQ-043 SHALL cover: with MAXPOOL_CTRL_STATS_EN, two back-to-back frames -> o_window_count reads 4 after each frame and resets on the second i_start.

Source files
------------

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_ctrl
//  Purpose  : Sequencing controller for a 2x2 / stride-2 max-pool datapath.
//             Even rows are written into a line buffer. Odd rows read the
//             line buffer back. A horizontal hold register pairs adjacent
//             columns. One pooled result is emitted per 2x2 window through
//             a valid/ready handshake with back-pressure.
//  Options  : MAXPOOL_CTRL_STATS_EN - adds o_window_count. It counts the
//             windows that downstream accepts in the current frame.
//  Ports    : i_clk, i_reset (async, active-high)
//             i_start                     - frame start, honoured in IDLE only
//             i_data_valid / o_data_ready - upstream pixel handshake
//             o_lb_wr_en, o_lb_rd_en,
//             o_lb_addr                   - line-buffer control, column address
//             o_hold_en                   - latch pixel into horizontal hold reg
//             o_pool_valid, o_pool_last,
//             i_pool_ready                - downstream pooled-result handshake
//             o_busy, o_frame_done        - status
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_ctrl #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_start,
    input  logic                              i_data_valid,
    output logic                              o_data_ready,
    output logic                              o_lb_wr_en,
    output logic                              o_lb_rd_en,
    output logic [$clog2(IMAGE_WIDTH)-1:0]    o_lb_addr,
    output logic                              o_hold_en,
    output logic                              o_pool_valid,
    output logic                              o_pool_last,
    input  logic                              i_pool_ready,
`ifdef MAXPOOL_CTRL_STATS_EN
    output logic [$clog2((IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2)):0] o_window_count,
`endif
    output logic                              o_busy,
    output logic                              o_frame_done
);

    localparam int AW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);

    localparam logic [AW-1:0] C_COL_LAST = AW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVEN_ROW = 2'd1,
        S_ODD_ROW  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t          state_q,      state_d;
    logic [AW-1:0]   col_q,        col_d;
    logic [RW-1:0]   row_q,        row_d;
    logic            pool_valid_q, pool_valid_d;
    logic            pool_last_q,  pool_last_d;
    logic            frame_done_q, frame_done_d;

    logic            w_in_rows;
    logic            w_ready;
    logic            w_accept;
    logic            w_col_last;
    logic            w_frame_end;
    logic            w_win_set;

    assign w_in_rows   = (state_q == S_EVEN_ROW) || (state_q == S_ODD_ROW);
    // Back-pressure: an unconsumed window blocks new pixels. This keeps the
    // datapath max register from being overwritten before downstream takes it.
    assign w_ready     = w_in_rows && !(pool_valid_q && !i_pool_ready);
    assign w_accept    = i_data_valid && w_ready;
    assign w_col_last  = (col_q == C_COL_LAST);
    assign w_frame_end = (state_q == S_ODD_ROW) && w_col_last && (row_q == C_ROW_LAST);
    // The second pixel of an odd-row column pair closes a 2x2 window. The
    // result becomes valid one cycle later, in step with the line-buffer read.
    assign w_win_set   = w_accept && (state_q == S_ODD_ROW) && col_q[0];

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        pool_valid_d = pool_valid_q;
        pool_last_d  = pool_last_q;
        frame_done_d = 1'b0;

        if (pool_valid_q && i_pool_ready) begin
            pool_valid_d = 1'b0;
            pool_last_d  = 1'b0;
        end
        // A window closing in the same cycle as a handshake takes priority.
        if (w_win_set) begin
            pool_valid_d = 1'b1;
            pool_last_d  = w_frame_end;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_EVEN_ROW;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_EVEN_ROW, S_ODD_ROW: begin
                if (w_accept) begin
                    if (w_col_last) begin
                        col_d = '0;
                        if (w_frame_end) begin
                            // Row returns to zero rather than running past the
                            // last row.
                            state_d = S_DONE;
                            row_d   = '0;
                        end else begin
                            row_d   = row_q + RW'(1);
                            state_d = (state_q == S_EVEN_ROW) ? S_ODD_ROW : S_EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                // Wait for the final window to drain before reporting done.
                if (!pool_valid_q || i_pool_ready) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            pool_valid_q <= 1'b0;
            pool_last_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pool_valid_q <= pool_valid_d;
            pool_last_q  <= pool_last_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef MAXPOOL_CTRL_STATS_EN
    localparam int CW = $clog2((IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2)) + 1;

    logic [CW-1:0] window_count_q, window_count_d;

    always_comb begin
        window_count_d = window_count_q;
        if ((state_q == S_IDLE) && i_start) begin
            window_count_d = '0;
        end else if (pool_valid_q && i_pool_ready) begin
            window_count_d = window_count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            window_count_q <= '0;
        end else begin
            window_count_q <= window_count_d;
        end
    end

    assign o_window_count = window_count_q;
`endif

    assign o_data_ready = w_ready;
    assign o_lb_wr_en   = w_accept && (state_q == S_EVEN_ROW);
    assign o_lb_rd_en   = w_accept && (state_q == S_ODD_ROW);
    assign o_hold_en    = w_accept && !col_q[0];
    assign o_lb_addr    = col_q;
    assign o_pool_valid = pool_valid_q;
    assign o_pool_last  = pool_last_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire
